// File: rtl/dfm_pkg.sv
// Shared types and constants for the frequency-meter measurement channels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dfm_pkg;

  // Gate alignment states of one measurement channel.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    OPEN   = 2'd2,
    DISARM = 2'd3
  } gate_state_t;

  // clk cycles to wait for a signal edge before the gate is forced to follow its enable.
  localparam int DEFAULT_GATE_TMO = 2**24;

  // Qualifiers attached to each measurement result.
  typedef struct packed {
    logic overrun;    // previous result was overwritten before it was consumed
    logic saturated;  // a counter stuck at all-ones during this gate
    logic timeout;    // gate opened or closed without a real signal edge
  } res_flags_t;

endpackage

// File: rtl/edge_sync.sv
// Brings an asynchronous input into clk_i and emits a one-cycle pulse on its rising edges.
// Latency: pulse follows the input rise by STAGES..STAGES+1 clk cycles.
// Backpressure: none; input phases shorter than 2 clk cycles may be missed.
// Ports: clk_i/rst_n_i (sync, active low), sig_i (async input), edge_o (rising-edge pulse).
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sig_i,
  output logic edge_o
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], sig_i};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign edge_o = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/gate_sync_ch.sv
// One frequency-meter channel: aligns the pre-gate enable to signal edges, counts ref cycles and periods.
// Latency: gate_sync_o rises 1 cycle after the opening edge pulse; result valid 1 cycle after the closing one.
// Backpressure: none upstream; an unconsumed result is overwritten by the next close and flagged overrun.
// Ports: clk_i, rst_n_i (sync, active low), gate_en_i, sig_i (async) -> gate_sync_o;
//        result port res_valid_o/res_ready_i carrying res_ref_o, res_sig_o, res_flags_o {overrun,saturated,timeout}.
module gate_sync_ch
  import dfm_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT   = DEFAULT_GATE_TMO
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 gate_en_i,
  input  logic                 sig_i,
  output logic                 gate_sync_o,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [CNT_WIDTH-1:0] res_ref_o,
  output logic [CNT_WIDTH-1:0] res_sig_o,
  output logic [2:0]           res_flags_o
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  gate_state_t          r_state;
  logic                 r_gate;
  logic [CNT_WIDTH-1:0] r_ref;
  logic [CNT_WIDTH-1:0] r_sig;
  logic                 r_sat;
  logic                 r_tmo_flag;
  logic [TMO_W-1:0]     r_tmo;
  logic                 r_valid;
  logic [CNT_WIDTH-1:0] r_res_ref;
  logic [CNT_WIDTH-1:0] r_res_sig;
  res_flags_t           r_res_flags;

  logic                 w_edge;
  logic                 w_waiting;
  logic                 w_fire;
  logic                 w_forced;
  logic                 w_close;
  logic                 w_sig_inc;
  logic                 w_sat_now;
  logic [CNT_WIDTH-1:0] w_ref_nxt;
  logic [CNT_WIDTH-1:0] w_sig_nxt;

  edge_sync #(.STAGES(2)) u_edge_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .sig_i   (sig_i),
    .edge_o  (w_edge)
  );

  // ARM and DISARM both wait for an edge; a timeout stands in for a missing one.
  // A real edge coinciding with the timeout wins, so the flag stays clear.
  assign w_waiting = (r_state == ARM) || (r_state == DISARM);
  assign w_fire    = w_waiting && (w_edge || (r_tmo == TMO_LAST));
  assign w_forced  = ~w_edge;
  assign w_close   = (r_state == DISARM) && w_fire;

  // Counter next values include the current cycle, so a close latches the closing edge and cycle.
  assign w_sig_inc = r_gate & w_edge;
  assign w_ref_nxt = (r_gate && !(&r_ref)) ? r_ref + CNT_WIDTH'(1) : r_ref;
  assign w_sig_nxt = (w_sig_inc && !(&r_sig)) ? r_sig + CNT_WIDTH'(1) : r_sig;
  // Saturation means an increment was refused at all-ones, i.e. the true count is lost.
  assign w_sat_now = (r_gate & (&r_ref)) | (w_sig_inc & (&r_sig));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_gate      <= 1'b0;
      r_ref       <= '0;
      r_sig       <= '0;
      r_sat       <= 1'b0;
      r_tmo_flag  <= 1'b0;
      r_tmo       <= '0;
      r_valid     <= 1'b0;
      r_res_ref   <= '0;
      r_res_sig   <= '0;
      r_res_flags <= '0;
    end else begin
      if (r_gate) begin
        r_ref <= w_ref_nxt;
        r_sig <= w_sig_nxt;
        r_sat <= r_sat | w_sat_now;
      end

      // Restarts from zero on every entry into a waiting state.
      if (w_waiting && !w_fire) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end else begin
        r_tmo <= '0;
      end

      // Edge/timeout is evaluated before gate_en_i in both waiting states.
      case (r_state)
        IDLE: begin
          if (gate_en_i) r_state <= ARM;
        end
        ARM: begin
          if (w_fire) begin
            r_state    <= OPEN;
            r_gate     <= 1'b1;
            r_ref      <= '0;
            r_sig      <= '0;
            r_sat      <= 1'b0;
            r_tmo_flag <= w_forced;
          end else if (!gate_en_i) begin
            r_state <= IDLE;
          end
        end
        OPEN: begin
          if (!gate_en_i) r_state <= DISARM;
        end
        DISARM: begin
          if (w_fire) begin
            r_state <= IDLE;
            r_gate  <= 1'b0;
          end else if (gate_en_i) begin
            r_state <= OPEN;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A close wins over a same-cycle handshake so the fresh result is never dropped.
      if (w_close) begin
        r_valid               <= 1'b1;
        r_res_ref             <= w_ref_nxt;
        r_res_sig             <= w_sig_nxt;
        r_res_flags.overrun   <= r_valid & ~res_ready_i;
        r_res_flags.saturated <= r_sat | w_sat_now;
        r_res_flags.timeout   <= r_tmo_flag | w_forced;
      end else if (r_valid && res_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign gate_sync_o = r_gate;
  assign res_valid_o = r_valid;
  assign res_ref_o   = r_res_ref;
  assign res_sig_o   = r_res_sig;
  assign res_flags_o = r_res_flags;

endmodule

// File: tb/tb_gate_sync_ch.sv
// Self-checking bench for gate_sync_ch: directed scenarios followed by randomized segments,
// all compared every cycle against a measurement-level reference model.
module tb_gate_sync_ch;

  localparam int CW   = 8;
  localparam int TMO  = 64;
  localparam int MAXV = 255;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          gate_en;
  logic          sig;
  logic          res_ready;
  logic          gate_sync_o;
  logic          res_valid_o;
  logic [CW-1:0] res_ref_o;
  logic [CW-1:0] res_sig_o;
  logic [2:0]    res_flags_o;

  always #5 clk = ~clk;

  gate_sync_ch #(.CNT_WIDTH(CW), .TIMEOUT(TMO)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .gate_en_i   (gate_en),
    .sig_i       (sig),
    .gate_sync_o (gate_sync_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready),
    .res_ref_o   (res_ref_o),
    .res_sig_o   (res_sig_o),
    .res_flags_o (res_flags_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 waiting to open, 2 open, 3 open and waiting to close.
  // Results come from cycle-index arithmetic: ref = close index - open index, sig = edges seen while open.
  int       cyc = 0;
  int       m_phase = 0;
  int       m_wait = 0;
  int       m_open_cyc = 0;
  int       m_nedges = 0;
  bit       m_open_forced = 0;
  bit       m_gate = 0;
  bit       m_valid = 0;
  int       m_ref = 0;
  int       m_sig = 0;
  bit [2:0] m_flags = 3'b000;
  bit       hist[$] = '{0, 0, 0, 0};

  // Square-wave generator for sig.
  int gen_hi = 5;
  int gen_lo = 5;
  int gen_cnt = 0;
  bit gen_stuck = 1;

  task automatic model_edge();
    bit e;
    bit closed;
    int ref_t;
    closed = 0;
    cyc++;
    // The detector reports a rise between the samples taken 3 and 2 edges ago.
    hist.push_back(sig);
    e = hist[2] && !hist[1];
    void'(hist.pop_front());
    if (!rst_n) begin
      hist    = '{0, 0, 0, 0};
      m_phase = 0;
      m_gate  = 0;
      m_valid = 0;
      m_ref   = 0;
      m_sig   = 0;
      m_flags = 3'b000;
      return;
    end
    case (m_phase)
      0: begin
        if (gate_en) begin m_phase = 1; m_wait = 0; end
      end
      1: begin
        if (e || m_wait == TMO - 1) begin
          m_phase = 2; m_open_cyc = cyc; m_nedges = 0; m_open_forced = !e;
        end else if (!gate_en) m_phase = 0;
        else m_wait++;
      end
      2: begin
        if (e) m_nedges++;
        if (!gate_en) begin m_phase = 3; m_wait = 0; end
      end
      default: begin
        if (e) m_nedges++;
        if (e || m_wait == TMO - 1) begin m_phase = 0; closed = 1; end
        else if (gate_en) m_phase = 2;
        else m_wait++;
      end
    endcase
    if (closed) begin
      ref_t   = cyc - m_open_cyc;
      m_flags = {m_valid && !res_ready, (ref_t > MAXV) || (m_nedges > MAXV), m_open_forced || !e};
      m_ref   = (ref_t > MAXV) ? MAXV : ref_t;
      m_sig   = (m_nedges > MAXV) ? MAXV : m_nedges;
      m_valid = 1;
    end else if (m_valid && res_ready) begin
      m_valid = 0;
    end
    m_gate = (m_phase == 2) || (m_phase == 3);
  endtask

  task automatic step();
    logic [18:0] exp_res;
    logic [18:0] got_res;
    if (!gen_stuck) begin
      gen_cnt++;
      if (gen_cnt >= (sig ? gen_hi : gen_lo)) begin
        sig = ~sig;
        gen_cnt = 0;
      end
    end
    @(posedge clk);
    model_edge();
    #1;
    checks++;
    assert (gate_sync_o === m_gate) else begin
      errors++;
      $error("FAIL gate_sync cyc=%0d got=%b exp=%b", cyc, gate_sync_o, m_gate);
    end
    checks++;
    assert (res_valid_o === m_valid) else begin
      errors++;
      $error("FAIL res_valid cyc=%0d got=%b exp=%b", cyc, res_valid_o, m_valid);
    end
    exp_res = {m_ref[7:0], m_sig[7:0], m_flags};
    got_res = {res_ref_o, res_sig_o, res_flags_o};
    checks++;
    assert (got_res === exp_res) else begin
      errors++;
      $error("FAIL result cyc=%0d got ref=%0d sig=%0d flags=%b exp ref=%0d sig=%0d flags=%b",
             cyc, res_ref_o, res_sig_o, res_flags_o, m_ref, m_sig, m_flags);
    end
  endtask

  task automatic rstep();
    res_ready = ($urandom_range(0, 3) != 0);
    rst_n     = ($urandom_range(0, 299) != 0);
    step();
  endtask

  initial begin
    int n;
    bit saw;
    rst_n = 1'b0; gate_en = 1'b0; sig = 1'b0; res_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();

    // Nominal: period 10, enable high 95 cycles, first edge right after arming.
    gen_hi = 5; gen_lo = 5; gen_cnt = 4; gen_stuck = 0;
    gate_en = 1'b1;
    repeat (95) step();
    gate_en = 1'b0;
    n = 0;
    while (!res_valid_o && n < 40) begin step(); n++; end
    checks++;
    assert (res_valid_o === 1'b1 && res_ref_o === 8'd100 && res_sig_o === 8'd10 && res_flags_o === 3'b000) else begin
      errors++;
      $error("FAIL nominal got valid=%b ref=%0d sig=%0d flags=%b exp 1/100/10/000",
             res_valid_o, res_ref_o, res_sig_o, res_flags_o);
    end

    // Handshake: two closes with ready low, second must carry overrun.
    res_ready = 1'b0; gen_hi = 3; gen_lo = 3; gen_cnt = 0;
    repeat (2) begin
      gate_en = 1'b1; repeat (30) step();
      gate_en = 1'b0; repeat (30) step();
    end
    checks++;
    assert (res_valid_o === 1'b1 && res_flags_o[2] === 1'b1) else begin
      errors++;
      $error("FAIL overrun got valid=%b flags=%b exp valid=1 overrun=1", res_valid_o, res_flags_o);
    end
    res_ready = 1'b1;
    step();
    checks++;
    assert (res_valid_o === 1'b0) else begin
      errors++;
      $error("FAIL handshake_drop got valid=%b exp 0", res_valid_o);
    end

    // Timeout: dead input, gate must still follow enable.
    gen_stuck = 1; sig = 1'b0;
    repeat (10) step();
    gate_en = 1'b1; n = 0;
    while (!gate_sync_o && n < 100) begin step(); n++; end
    checks++;
    assert (gate_sync_o === 1'b1 && n <= 66) else begin
      errors++;
      $error("FAIL tmo_open got gate=%b after %0d cycles exp 1 within 66", gate_sync_o, n);
    end
    gate_en = 1'b0; n = 0;
    while (!res_valid_o && n < 100) begin step(); n++; end
    checks++;
    assert (res_valid_o === 1'b1 && n >= 64 && n <= 66 && res_flags_o[0] === 1'b1) else begin
      errors++;
      $error("FAIL tmo_close got valid=%b cycles=%0d flags=%b exp valid=1 cycles 64..66 timeout=1",
             res_valid_o, n, res_flags_o);
    end

    // Saturation: period 4, 100 periods into an 8-bit ref counter.
    gen_stuck = 0; gen_hi = 2; gen_lo = 2; gen_cnt = 0;
    gate_en = 1'b1;
    repeat (400) step();
    gate_en = 1'b0; n = 0;
    while (!res_valid_o && n < 40) begin step(); n++; end
    checks++;
    assert (res_valid_o === 1'b1 && res_ref_o === 8'hFF && res_flags_o[1] === 1'b1) else begin
      errors++;
      $error("FAIL saturate got valid=%b ref=%0d flags=%b exp valid=1 ref=255 saturated=1",
             res_valid_o, res_ref_o, res_flags_o);
    end

    // Enable pulse while armed and no edge: gate never opens, no result.
    gen_stuck = 1; sig = 1'b0;
    repeat (10) step();
    gate_en = 1'b1; repeat (3) step();
    gate_en = 1'b0; saw = 0;
    repeat (70) begin step(); if (gate_sync_o || res_valid_o) saw = 1; end
    checks++;
    assert (saw === 1'b0) else begin
      errors++;
      $error("FAIL arm_abort got gate_or_valid_seen=%b exp 0", saw);
    end

    // Reset in the middle of an open gate discards the measurement.
    gen_stuck = 0; gen_hi = 4; gen_lo = 4; gen_cnt = 0;
    gate_en = 1'b1; n = 0;
    while (!gate_sync_o && n < 60) begin step(); n++; end
    repeat (5) step();
    rst_n = 1'b0; gate_en = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    assert (gate_sync_o === 1'b0 && res_valid_o === 1'b0) else begin
      errors++;
      $error("FAIL reset_mid got gate=%b valid=%b exp 0/0", gate_sync_o, res_valid_o);
    end
    saw = 0;
    repeat (60) begin step(); if (res_valid_o) saw = 1; end
    checks++;
    assert (saw === 1'b0) else begin
      errors++;
      $error("FAIL reset_discard got valid_seen=%b exp 0", saw);
    end

    // Randomized segments: periods, dead input, ready, enable lengths and sporadic resets.
    for (int s = 0; s < 30; s++) begin
      int len_on;
      int len_off;
      gen_stuck = ($urandom_range(0, 5) == 0);
      gen_hi    = $urandom_range(2, 9);
      gen_lo    = $urandom_range(2, 9);
      gen_cnt   = 0;
      len_on    = $urandom_range(1, 120);
      len_off   = $urandom_range(1, 120);
      gate_en = 1'b1;
      repeat (len_on) rstep();
      gate_en = 1'b0;
      repeat (len_off) rstep();
    end
    rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
